// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game phase sequencer for the ball/brick datapath
//
// Purpose: steps the game through idle, level load, aim, play, pause,
// game-over and all-clear phases; owns level, lives, launch angle and the
// ball step period. Every output is a register.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   btn_start  debounced start button level (clk-synchronous)
//   btn_left   debounced left button level (clk-synchronous)
//   btn_right  debounced right button level (clk-synchronous)
//   dead       ball lost, held by the datapath until it sees AIM
//   win        bricks cleared, held by the datapath until it sees AIM
//   state      0 IDLE, 1 LOAD, 2 AIM, 3 PLAY, 4 OVER, 5 CLEAR, 6 PAUSE
//   level      current level
//   angle      launch angle 0..5
//   period     ball step period in clocks
//   lives      remaining lives
//   game_over  high in OVER
//   all_clear  high in CLEAR
module game_ctrl #(
  parameter int unsigned INIT_LIVES    = 3,
  parameter int unsigned NUM_LEVELS    = 6,
  parameter int unsigned BASE_PERIOD   = 500000,
  parameter int unsigned PERIOD_STEP   = 50000,
  parameter int unsigned MIN_PERIOD    = 100000,
  parameter int unsigned ANGLE_DEFAULT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        dead,
  input  logic        win,
  output logic [2:0]  state,
  output logic [2:0]  level,
  output logic [2:0]  angle,
  output logic [19:0] period,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        all_clear
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_AIM   = 3'd2,
    S_PLAY  = 3'd3,
    S_OVER  = 3'd4,
    S_CLEAR = 3'd5,
    S_PAUSE = 3'd6
  } state_t;

  localparam logic [2:0]  LVL_MAX    = 3'(NUM_LEVELS - 1);
  localparam logic [2:0]  ANG_MAX    = 3'd5;
  localparam logic [2:0]  ANG_DEF    = 3'(ANGLE_DEFAULT);
  localparam logic [1:0]  LIVES_INIT = 2'(INIT_LIVES);
  localparam logic [19:0] P_BASE     = 20'(BASE_PERIOD);
  localparam logic [20:0] P_STEP     = 21'(PERIOD_STEP);
  localparam logic [20:0] P_MIN      = 21'(MIN_PERIOD);

  state_t      state_q, state_d;
  logic [2:0]  level_d, angle_d;
  logic [19:0] period_d;
  logic [1:0]  lives_d;
  logic        game_over_d, all_clear_d;
  logic [1:0]  load_cnt_q, load_cnt_d;
  logic        armed_q, armed_d;
  logic        prev_start, prev_left, prev_right;
  logic        start_e, left_e, right_e;
  logic [20:0] p_diff;

  assign state   = state_q;
  assign start_e = btn_start & ~prev_start;
  assign left_e  = btn_left  & ~prev_left;
  assign right_e = btn_right & ~prev_right;

  // History regs come out of reset at 1 so a button held through reset
  // does not look like a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      level      <= 3'd0;
      angle      <= ANG_DEF;
      period     <= P_BASE;
      lives      <= LIVES_INIT;
      game_over  <= 1'b0;
      all_clear  <= 1'b0;
      load_cnt_q <= 2'd0;
      armed_q    <= 1'b0;
      prev_start <= 1'b1;
      prev_left  <= 1'b1;
      prev_right <= 1'b1;
    end else begin
      state_q    <= state_d;
      level      <= level_d;
      angle      <= angle_d;
      period     <= period_d;
      lives      <= lives_d;
      game_over  <= game_over_d;
      all_clear  <= all_clear_d;
      load_cnt_q <= load_cnt_d;
      armed_q    <= armed_d;
      prev_start <= btn_start;
      prev_left  <= btn_left;
      prev_right <= btn_right;
    end
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level;
    angle_d    = angle;
    period_d   = period;
    lives_d    = lives;
    load_cnt_d = load_cnt_q;
    armed_d    = armed_q;
    // 21-bit difference: bit 20 set means the step would underflow.
    p_diff     = {1'b0, period} - P_STEP;

    case (state_q)
      S_IDLE: begin
        if (left_e && !right_e && level != 3'd0)
          level_d = level - 3'd1;
        else if (right_e && !left_e && level != LVL_MAX)
          level_d = level + 3'd1;
        if (start_e) begin
          lives_d    = LIVES_INIT;
          period_d   = P_BASE;
          load_cnt_d = 2'd0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_cnt_q == 2'd1)
          state_d = S_AIM;
        else
          load_cnt_d = load_cnt_q + 2'd1;
      end
      S_AIM: begin
        if (left_e && !right_e && angle != 3'd0)
          angle_d = angle - 3'd1;
        else if (right_e && !left_e && angle != ANG_MAX)
          angle_d = angle + 3'd1;
        if (start_e) begin
          armed_d = 1'b0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // The entry cycle only arms; dead/win may still be stale from the
        // datapath's view of the previous phase.
        armed_d = 1'b1;
        if (armed_q && win) begin
          if (level == LVL_MAX) begin
            state_d = S_CLEAR;
          end else begin
            level_d    = level + 3'd1;
            period_d   = (p_diff[20] || p_diff < P_MIN) ? P_MIN[19:0] : p_diff[19:0];
            load_cnt_d = 2'd0;
            state_d    = S_LOAD;
          end
        end else if (armed_q && dead) begin
          if (lives <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end else begin
            lives_d = lives - 2'd1;
            state_d = S_AIM;
          end
        end else if (start_e) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start_e) begin
          armed_d = 1'b0;
          state_d = S_PLAY;
        end
      end
      S_OVER, S_CLEAR: begin
        if (start_e)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Keeps angle at its default for every cycle spent in IDLE.
    if (state_d == S_IDLE)
      angle_d = ANG_DEF;
    game_over_d = (state_d == S_OVER);
    all_clear_d = (state_d == S_CLEAR);
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer that drives the ball/brick datapath through its phases: idle, level load, aim, play.
- Owns the level number, remaining lives, launch angle and the ball step period.
- Reacts to the datapath's dead/win flags and to debounced player buttons.
- All outputs are registered and feed the ball logic and display logic directly.

Parameters:
- INIT_LIVES, 3, lives granted at game start (1..3).
- NUM_LEVELS, 6, number of levels; legal level values are 0..NUM_LEVELS-1 (max 8).
- BASE_PERIOD, 500000, ball step period in clocks at game start.
- PERIOD_STEP, 50000, amount period shrinks per cleared level.
- MIN_PERIOD, 100000, floor on period.
- ANGLE_DEFAULT, 4, launch angle after reset and in IDLE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- btn_start  in  1  debounced, clk-synchronous level signal
- btn_left  in  1  debounced, clk-synchronous level signal
- btn_right  in  1  debounced, clk-synchronous level signal
- dead  in  1  ball lost (held by datapath until it sees state 2)
- win  in  1  all bricks cleared (held by datapath until it sees state 2)
- state  out  3  0 IDLE, 1 LOAD, 2 AIM, 3 PLAY, 4 OVER, 5 CLEAR, 6 PAUSE
- level  out  3  current level
- angle  out  3  launch angle 0..5
- period  out  20  ball step period in clocks
- lives  out  2  remaining lives
- game_over  out  1  high in OVER
- all_clear  out  1  high in CLEAR

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=0, level=0, angle=ANGLE_DEFAULT, period=BASE_PERIOD, lives=INIT_LIVES, game_over=0, all_clear=0, button history regs=1.
  - History regs reset to 1 so a button held through reset produces no edge.
- Edge detection:
  - start_e = btn_start & ~prev_start; likewise left_e and right_e.
  - Only rising edges act; each edge acts exactly once.
- IDLE:
  - left_e decrements level, saturating at 0; right_e increments level, saturating at NUM_LEVELS-1. This is start-level select.
  - angle is held at ANGLE_DEFAULT.
  - On start_e: lives=INIT_LIVES, period=BASE_PERIOD, then go to LOAD. level is kept.
- LOAD:
  - Held exactly 2 cycles (2-bit counter cleared on entry), then go to AIM.
- AIM:
  - left_e decrements angle, saturating at 0; right_e increments angle, saturating at 5.
  - On start_e, go to PLAY. AIM lasts at least 1 cycle, which lets the datapath clear dead/win.
- PLAY:
  - An arm flag is cleared on entry; dead/win are ignored in the entry cycle.
  - Priority once armed: win > dead > start_e.
  - win: if level==NUM_LEVELS-1, go to CLEAR. Otherwise level+1, period=max(period-PERIOD_STEP, MIN_PERIOD), go to LOAD. Compute the subtraction at 21 bits so there is no underflow.
  - dead: if lives==1, lives=0 and go to OVER. Otherwise lives-1 and go to AIM; bricks are untouched because there is no LOAD.
  - start_e: go to PAUSE.
- PAUSE:
  - Datapath is frozen because it ignores state 6.
  - On start_e, return to PLAY; the arm flag is re-cleared.
- OVER / CLEAR:
  - game_over (resp. all_clear) is asserted.
  - On start_e, go to IDLE; flags drop on leaving.
- Simultaneous left_e and right_e: no change to angle or level.
- Reset mid-game: immediate return to reset values regardless of state.
- Illegal state (7): go to IDLE on the next cycle.
- Outputs change only on the clk edge after the causing input; latency from input to output is 1 cycle.

Test Plan:
1. Reset with btn_start held high, then release and re-press → state stays 0 until the re-press edge; state goes 0→1 and holds 2 cycles, then 2; period=500000, lives=3.
2. In AIM, 6 right pulses from angle 4, then 1 left pulse → angle 5,5,5,5,5,5 then 4. In IDLE, 9 right pulses → level saturates at 5.
3. PLAY at level 0, pulse win → state 1, level 1, period 450000. Repeat until level 5, then win → state 5, all_clear=1; period never drops below 100000.
4. PLAY with lives=3, dead held 3 cycles → lives=2, state 2, exactly one decrement. Third death from lives=1 → lives=0, state 4, game_over=1; start_e → state 0.
5. dead and win asserted in the same cycle at level 2 → state 1, level 3, lives unchanged. win asserted in the PLAY entry cycle only → ignored, state stays 3.
6. PLAY, start_e → state 6. win asserted while in PAUSE → ignored. start_e → state 3. Assert rst mid-PAUSE → all outputs return to reset values asynchronously.
